// File: rtl/avg_upsample_pkg.sv
// Shared types and helpers for the 2x2 average upsampler.
// Rounding mode of the kernel is selected by AVG_UPSAMPLE_ROUND_EN.
package avg_upsample_pkg;

    typedef enum logic {LOAD, EMIT} ups_state_t;

    localparam int unsigned SUM_PAD = 2;

    // log2 of the number of pooled pixels covering output (r,c) of an (n+1)x(n+1) map
    function automatic logic [1:0] contrib_shift(input int unsigned r, input int unsigned c,
                                                 input int unsigned n);
        logic r_edge;
        logic c_edge;
        r_edge = (r == 0) || (r == n);
        c_edge = (c == 0) || (c == n);
        case ({r_edge, c_edge})
            2'b11:   return 2'd0;
            2'b00:   return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/ups_kernel.sv
// Combinational average of up to four masked pooled pixels.
// AVG_UPSAMPLE_ROUND_EN selects round-half-up, otherwise the sum is truncated.
module ups_kernel
    import avg_upsample_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0][DATA_W-1:0] px,
    input  logic [1:0]             shift,
    output logic [DATA_W-1:0]      avg_c
);

    localparam int unsigned SUM_W = DATA_W + SUM_PAD;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_adj;
`ifdef AVG_UPSAMPLE_ROUND_EN
    logic [SUM_W-1:0] rnd;
`endif

    always_comb begin
        sum = SUM_W'(px[0]) + SUM_W'(px[1]) + SUM_W'(px[2]) + SUM_W'(px[3]);
`ifdef AVG_UPSAMPLE_ROUND_EN
        // half of K, so the shift rounds half up; K=1 adds nothing
        case (shift)
            2'd1:    rnd = SUM_W'(1);
            2'd2:    rnd = SUM_W'(2);
            default: rnd = '0;
        endcase
        sum_adj = sum + rnd;
`else
        sum_adj = sum;
`endif
        avg_c = DATA_W'(sum_adj >> shift);
    end

endmodule

// File: rtl/avg_upsample.sv
// Streaming N x N -> (N+1) x (N+1) upsampler inverting overlapping 2x2 average pooling.
// Optional round-half-up averaging via AVG_UPSAMPLE_ROUND_EN (default: truncate).
module avg_upsample
    import avg_upsample_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int unsigned IDX_W = $clog2(N + 1);
    localparam int unsigned AW    = $clog2(N);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(N);
    localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(N - 1);

    ups_state_t        state;
    logic [IDX_W-1:0]  irow, icol, orow, ocol;
    logic [IDX_W-1:0]  krow, kcol;
    logic [DATA_W-1:0] p [N][N];

    logic                   r_lo_ok, r_hi_ok, c_lo_ok, c_hi_ok;
    logic [AW-1:0]          ri_lo, ri_hi, ci_lo, ci_hi;
    logic [3:0][DATA_W-1:0] taps;
    logic [1:0]             shift;
    logic [DATA_W-1:0]      kern_c;

    // Position of the pixel to be registered next: (0,0) while loading, else the successor of (orow,ocol)
    always_comb begin
        krow = '0;
        kcol = '0;
        if (state == EMIT) begin
            if (ocol == OUT_LAST) begin
                krow = orow + IDX_W'(1);
                kcol = '0;
            end else begin
                krow = orow;
                kcol = ocol + IDX_W'(1);
            end
        end
    end

    // Gather the up-to-four covering pooled pixels, zeroing those outside the map
    always_comb begin
        r_lo_ok = (krow != '0);
        r_hi_ok = (krow != OUT_LAST);
        c_lo_ok = (kcol != '0);
        c_hi_ok = (kcol != OUT_LAST);
        ri_lo   = r_lo_ok ? AW'(krow - IDX_W'(1)) : '0;
        ri_hi   = r_hi_ok ? AW'(krow) : '0;
        ci_lo   = c_lo_ok ? AW'(kcol - IDX_W'(1)) : '0;
        ci_hi   = c_hi_ok ? AW'(kcol) : '0;
        taps[0] = (r_lo_ok && c_lo_ok) ? p[ri_lo][ci_lo] : '0;
        taps[1] = (r_lo_ok && c_hi_ok) ? p[ri_lo][ci_hi] : '0;
        taps[2] = (r_hi_ok && c_lo_ok) ? p[ri_hi][ci_lo] : '0;
        taps[3] = (r_hi_ok && c_hi_ok) ? p[ri_hi][ci_hi] : '0;
        shift   = contrib_shift(32'(krow), 32'(kcol), N);
    end

    ups_kernel #(.DATA_W(DATA_W)) u_kernel (
        .px    (taps),
        .shift (shift),
        .avg_c (kern_c)
    );

    // Frame buffer is not reset: a partial frame is simply overwritten by the next one
    always_ff @(posedge clk) begin
        if (state == LOAD && s_valid && s_ready) begin
            p[AW'(irow)][AW'(icol)] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            irow    <= '0;
            icol    <= '0;
            orow    <= '0;
            ocol    <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        if (icol == IN_LAST) begin
                            icol <= '0;
                            if (irow == IN_LAST) begin
                                irow    <= '0;
                                state   <= EMIT;
                                s_ready <= 1'b0;
                                m_valid <= 1'b1;
                                m_data  <= kern_c;
                                m_last  <= 1'b0;
                            end else begin
                                irow <= irow + IDX_W'(1);
                            end
                        end else begin
                            icol <= icol + IDX_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state   <= LOAD;
                            orow    <= '0;
                            ocol    <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            orow   <= krow;
                            ocol   <= kcol;
                            m_data <= kern_c;
                            m_last <= (krow == OUT_LAST) && (kcol == OUT_LAST);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
